// File: rtl/neuron_lif_if.sv
// Bundle of the neuron's configuration, spike inputs and observable outputs.
// The driver side (layer controller or bench) uses master, the neuron uses slave.
interface neuron_lif_if #(
   parameter int N_IN      = 4,
   parameter int W_WIDTH   = 4,
   parameter int P_WIDTH   = 8,
   parameter int TH_WIDTH  = 4,
   parameter int REF_WIDTH = 3
) ();
   logic                      en;
   logic [N_IN*W_WIDTH-1:0]   weight;
   logic [TH_WIDTH-1:0]       threshold;
   logic [TH_WIDTH-1:0]       leak;
   logic [REF_WIDTH-1:0]      refrac;
   logic [N_IN-1:0]           data_in;
   logic [N_IN-1:0]           sign_in;
   logic                      data_out;
   logic                      sign_out;
   logic [P_WIDTH-1:0]        potential;
   logic                      refrac_busy;

   modport master (
      output en, weight, threshold, leak, refrac, data_in, sign_in,
      input  data_out, sign_out, potential, refrac_busy
   );

   modport slave (
      input  en, weight, threshold, leak, refrac, data_in, sign_in,
      output data_out, sign_out, potential, refrac_busy
   );
endinterface

// File: rtl/neuron_lif.sv
// Leaky integrate-and-fire neuron with N_IN signed spike channels, per-channel
// signed weights, saturating membrane potential, programmable leak/threshold
// and a refractory period after each output spike.
module neuron_lif #(
   parameter int N_IN      = 4,
   parameter int W_WIDTH   = 4,
   parameter int P_WIDTH   = 8,
   parameter int TH_WIDTH  = 4,
   parameter int REF_WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   neuron_lif_if.slave    bus
);

   // Full-width sum, widened further so leak arithmetic can never wrap either.
   localparam int SUM_W  = P_WIDTH + $clog2(N_IN) + 2;
   localparam int CALC_W = SUM_W + TH_WIDTH + 1;

   localparam logic signed [CALC_W-1:0] P_MAX = {{(CALC_W-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
   localparam logic signed [CALC_W-1:0] P_MIN = ~P_MAX;
   localparam logic signed [CALC_W-1:0] ZERO  = '0;

   typedef enum logic {
      ST_INTEGRATE   = 1'b0,
      ST_REFRACTORY  = 1'b1
   } state_t;

   state_t                      state_reg, state_next;
   logic [REF_WIDTH-1:0]        cnt_reg, cnt_next;
   logic signed [P_WIDTH-1:0]   pot_reg, pot_next;
   logic                        dout_reg, dout_next;
   logic                        sout_reg, sout_next;

   logic signed [CALC_W-1:0]    contrib_ext [N_IN];
   logic signed [CALC_W-1:0]    sum_all;
   logic signed [CALC_W-1:0]    pot_ext;
   logic signed [CALC_W-1:0]    leak_ext;
   logic signed [CALC_W-1:0]    thr_ext;
   logic signed [CALC_W-1:0]    leaked;
   logic signed [CALC_W-1:0]    total;
   logic signed [CALC_W-1:0]    n_wide;
   logic                        fire_pos, fire_neg;

   // Per-channel signed contribution; negation in W_WIDTH+1 bits keeps -(-2^(W-1)) exact.
   generate
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
         logic signed [W_WIDTH:0] w_ext;
         logic signed [W_WIDTH:0] c_val;
         assign w_ext = {bus.weight[gi*W_WIDTH + W_WIDTH - 1], bus.weight[gi*W_WIDTH +: W_WIDTH]};
         assign c_val = !bus.data_in[gi] ? '0 :
                        (bus.sign_in[gi] ? -w_ext : w_ext);
         assign contrib_ext[gi] = {{(CALC_W-W_WIDTH-1){c_val[W_WIDTH]}}, c_val};
      end
   endgenerate

   // Sum all channel contributions at full width.
   always_comb begin
      sum_all = ZERO;
      for (int i = 0; i < N_IN; i++) begin
         sum_all = sum_all + contrib_ext[i];
      end
   end

   assign pot_ext  = {{(CALC_W-P_WIDTH){pot_reg[P_WIDTH-1]}}, pot_reg};
   assign leak_ext = {{(CALC_W-TH_WIDTH){1'b0}}, bus.leak};
   assign thr_ext  = {{(CALC_W-TH_WIDTH){1'b0}}, bus.threshold};

   // Leak toward zero without crossing it, then add the input sum and saturate.
   always_comb begin
      leaked = ZERO;
      if (pot_ext > ZERO) begin
         leaked = (pot_ext > leak_ext) ? (pot_ext - leak_ext) : ZERO;
      end else if (pot_ext < ZERO) begin
         leaked = (-pot_ext > leak_ext) ? (pot_ext + leak_ext) : ZERO;
      end
      total = leaked + sum_all;
      if (total > P_MAX) begin
         n_wide = P_MAX;
      end else if (total < P_MIN) begin
         n_wide = P_MIN;
      end else begin
         n_wide = total;
      end
   end

   assign fire_pos = (bus.threshold != '0) && (n_wide >= thr_ext);
   assign fire_neg = (bus.threshold != '0) && (n_wide <= -thr_ext);

   // State, counter, potential and output spike registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_INTEGRATE;
         cnt_reg   <= '0;
         pot_reg   <= '0;
         dout_reg  <= 1'b0;
         sout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pot_reg   <= pot_next;
         dout_reg  <= dout_next;
         sout_reg  <= sout_next;
      end
   end

   // Next-state logic: integrate/fire, or count down the refractory period.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pot_next   = pot_reg;
      dout_next  = 1'b0;
      sout_next  = 1'b0;
      if (bus.en) begin
         case (state_reg)
            ST_INTEGRATE: begin
               if (fire_pos || fire_neg) begin
                  pot_next  = '0;
                  dout_next = 1'b1;
                  sout_next = fire_neg;
                  if (bus.refrac != '0) begin
                     state_next = ST_REFRACTORY;
                     cnt_next   = bus.refrac;
                  end
               end else begin
                  pot_next = n_wide[P_WIDTH-1:0];
               end
            end
            ST_REFRACTORY: begin
               pot_next = '0;
               if (cnt_reg <= REF_WIDTH'(1)) begin
                  cnt_next   = '0;
                  state_next = ST_INTEGRATE;
               end else begin
                  cnt_next = cnt_reg - REF_WIDTH'(1);
               end
            end
            default: begin
               state_next = ST_INTEGRATE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign bus.data_out    = dout_reg;
   assign bus.sign_out    = sout_reg;
   assign bus.potential   = pot_reg;
   assign bus.refrac_busy = (state_reg == ST_REFRACTORY);

endmodule
